// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared state encoding and counter sizing for the serializer
package piso_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int GAP_CNT_W = 4;

    function automatic int CNT_W(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load shift register with fixed direction and serial tap
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_tap
);

    logic [WIDTH-1:0] r_data;

    // Zero fill means the register is empty once the last bit has been shifted past the tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            if (MSB_FIRST != 0) begin
                r_data <= {r_data[WIDTH-2:0], 1'b0};
            end else begin
                r_data <= {1'b0, r_data[WIDTH-1:1]};
            end
        end
    end

    assign o_tap = (MSB_FIRST != 0) ? r_data[WIDTH-1] : r_data[0];

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - valid/ready word intake, serial bit output with frame strobes and gap
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam int CW = CNT_W(WIDTH);
    localparam logic [CW-1:0]        LAST_BIT = CW'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0] LAST_GAP = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t                 r_state;
    logic [CW-1:0]          r_bit_cnt;
    logic [GAP_CNT_W-1:0]   r_gap_cnt;
    logic                   r_ser_valid;
    logic                   r_frame_start;
    logic                   r_frame_end;

    logic                   w_last;
    logic                   w_xfer;
    logic                   w_shift;
    logic                   w_tap;
    logic [CW-1:0]          w_cnt_next;

    assign w_last     = (r_state == ST_SHIFT) && (r_bit_cnt == LAST_BIT);
    assign load_ready = (r_state == ST_IDLE) || ((GAP_CYCLES == 0) && w_last);
    assign w_xfer     = load_valid && load_ready;
    assign w_shift    = (r_state == ST_SHIFT);
    assign w_cnt_next = r_bit_cnt + CW'(1);

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_xfer),
        .i_shift (w_shift),
        .i_data  (load_data),
        .o_tap   (w_tap)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_ser_valid   <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bit_cnt     <= '0;
                    r_gap_cnt     <= '0;
                    r_frame_end   <= 1'b0;
                    if (w_xfer) begin
                        r_state       <= ST_SHIFT;
                        r_ser_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_ser_valid   <= 1'b0;
                        r_frame_start <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!w_last) begin
                        r_bit_cnt     <= w_cnt_next;
                        r_ser_valid   <= 1'b1;
                        r_frame_start <= 1'b0;
                        r_frame_end   <= (w_cnt_next == LAST_BIT);
                    end else if (GAP_CYCLES > 0) begin
                        r_state       <= ST_GAP;
                        r_bit_cnt     <= '0;
                        r_gap_cnt     <= '0;
                        r_ser_valid   <= 1'b0;
                        r_frame_start <= 1'b0;
                        r_frame_end   <= 1'b0;
                    end else if (w_xfer) begin
                        // Back-to-back reload: the next cycle already carries the new first bit.
                        r_bit_cnt     <= '0;
                        r_ser_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_frame_end   <= 1'b0;
                    end else begin
                        r_state       <= ST_IDLE;
                        r_bit_cnt     <= '0;
                        r_ser_valid   <= 1'b0;
                        r_frame_start <= 1'b0;
                        r_frame_end   <= 1'b0;
                    end
                end
                ST_GAP: begin
                    r_ser_valid   <= 1'b0;
                    r_frame_start <= 1'b0;
                    r_frame_end   <= 1'b0;
                    if (r_gap_cnt == LAST_GAP) begin
                        r_state   <= ST_IDLE;
                        r_gap_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_bit_cnt     <= '0;
                    r_gap_cnt     <= '0;
                    r_ser_valid   <= 1'b0;
                    r_frame_start <= 1'b0;
                    r_frame_end   <= 1'b0;
                end
            endcase
        end
    end

    assign ser_out     = w_tap & r_ser_valid;
    assign ser_valid   = r_ser_valid;
    assign frame_start = r_frame_start;
    assign frame_end   = r_frame_end;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - four serializer configurations checked against a frame-timing model
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       lv [4];
    logic [7:0] ld [4];
    logic       lr [4];
    logic       so [4];
    logic       sv [4];
    logic       fs [4];
    logic       fe [4];
    logic       bz [4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int          start_at [4];
    int          free_at  [4];
    logic [31:0] word     [4];
    bit          got      [4];

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr[0]),
        .ser_out(so[0]), .ser_valid(sv[0]), .frame_start(fs[0]), .frame_end(fe[0]), .busy(bz[0]));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset), .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr[1]),
        .ser_out(so[1]), .ser_valid(sv[1]), .frame_start(fs[1]), .frame_end(fe[1]), .busy(bz[1]));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(3)) u_dut2 (
        .clk(clk), .reset(reset), .load_valid(lv[2]), .load_data(ld[2]), .load_ready(lr[2]),
        .ser_out(so[2]), .ser_valid(sv[2]), .frame_start(fs[2]), .frame_end(fe[2]), .busy(bz[2]));
    piso_serializer #(.WIDTH(2), .MSB_FIRST(1), .GAP_CYCLES(0)) u_dut3 (
        .clk(clk), .reset(reset), .load_valid(lv[3]), .load_data(ld[3][1:0]), .load_ready(lr[3]),
        .ser_out(so[3]), .ser_valid(sv[3]), .frame_start(fs[3]), .frame_end(fe[3]), .busy(bz[3]));

    function automatic int p_w(input int k);
        return (k == 3) ? 2 : 8;
    endfunction

    function automatic int p_msb(input int k);
        return (k == 1) ? 0 : 1;
    endfunction

    function automatic int p_gap(input int k);
        return (k == 2) ? 3 : 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            start_at[k] = -1000;
            free_at[k]  = 0;
        end
    endtask

    task automatic chk(input string tag, input int k, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d cycle %0d: observed=%b expected=%b", tag, k, cyc, obs, exp);
        end
    endtask

    // A frame accepted on edge e occupies cycles e..e+W-1, then W..W+G-1 are gap cycles.
    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            int   w, g, idx, bi;
            bit   in_f;
            logic eb;
            w    = p_w(k);
            g    = p_gap(k);
            idx  = cyc - start_at[k];
            in_f = (idx >= 0) && (idx < w);
            bi   = (p_msb(k) != 0) ? (w - 1 - idx) : idx;
            eb   = in_f ? word[k][bi] : 1'b0;
            chk("ser_valid",   k, sv[k], in_f);
            chk("ser_out",     k, so[k], eb);
            chk("frame_start", k, fs[k], in_f && (idx == 0));
            chk("frame_end",   k, fe[k], in_f && (idx == w - 1));
            chk("load_ready",  k, lr[k], cyc >= free_at[k]);
            chk("busy",        k, bz[k], (idx >= 0) && (idx < w + g));
        end
    endtask

    task automatic step();
        bit xf [4];
        for (int k = 0; k < 4; k++)
            xf[k] = (reset === 1'b1) && (lv[k] === 1'b1) && (cyc >= free_at[k]);
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 4; k++) begin
            got[k] = xf[k];
            if (xf[k]) begin
                start_at[k] = cyc;
                word[k]     = 32'(ld[k]);
                free_at[k]  = (p_gap(k) == 0) ? cyc + p_w(k) - 1 : cyc + p_w(k) + p_gap(k);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int k, input logic [7:0] d);
        bit done;
        done  = 1'b0;
        lv[k] = 1'b1;
        ld[k] = d;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            done = got[k];
        end
        lv[k] = 1'b0;
        n_checks++;
        assert (done) else begin
            n_fail++;
            $error("FAIL send_timeout dut%0d cycle %0d: observed=no handshake expected=handshake", k, cyc);
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lv[k] = 1'b1;
            ld[k] = 8'hFF;
            word[k] = '0;
            got[k] = 1'b0;
        end
        model_reset();
        @(negedge clk);
        check_all();
        idle(3);

        reset = 1'b1;
        for (int k = 0; k < 4; k++) lv[k] = 1'b0;
        idle(2);

        send(0, 8'hA5);
        idle(10);
        send(1, 8'h01);
        idle(10);

        send(0, 8'hFF);
        send(0, 8'h00);
        idle(10);

        send(2, 8'h96);
        send(2, 8'h5A);
        idle(16);

        send(3, 8'h02);
        send(3, 8'h01);
        send(3, 8'h03);
        idle(4);

        // Asynchronous reset in the middle of a frame, observed between clock edges.
        send(0, 8'hC3);
        idle(4);
        #2 reset = 1'b0;
        #1 model_reset();
        check_all();
        idle(2);
        reset = 1'b1;
        idle(1);
        send(0, 8'h3C);
        idle(10);

        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) begin
                lv[k] = 1'($urandom_range(0, 1));
                ld[k] = 8'($urandom);
            end
            step();
        end
        for (int k = 0; k < 4; k++) lv[k] = 1'b0;
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
